audio_mix_dac: RTL

Parametrised stereo audio mixer and 1-bit DAC for the PCXT system top. It takes N signed PCM sources (OPL2, Tandy PSG, PC speaker, future sources), applies a per-channel shift gain, mute and left/right routing, and sums them with saturation. The mixed result drives one 1-bit modulator per side. A runtime mode selects either the legacy leaky-integrator comparator or a first-order delta-sigma modulator.

---
 rtl/audio_mix_pkg.sv | 33 +++
 rtl/audio_mix_dac_sd_dac_1bit.sv | 45 ++++
 rtl/audio_mix_dac.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the stereo PCM mixer and its 1-bit DAC back end.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CLAMP = 2'd2
  } mix_state_t;

  localparam logic DAC_LEAKY = 1'b0;
  localparam logic DAC_DSM   = 1'b1;

  // Headroom for a 7-bit shift gain plus the sum of all channels, plus sign.
  function automatic int acc_width(input int channels, input int in_width);
    return in_width + 8 + $clog2(channels);
  endfunction

  // Returns {clip, value}; value is the accumulator saturated to in_width bits.
  function automatic logic [64:0] clamp_sat(input logic signed [63:0] acc, input int in_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (in_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (in_width - 1));
    if (acc > hi) begin
      clamp_sat = {1'b1, hi};
    end else if (acc < lo) begin
      clamp_sat = {1'b1, lo};
    end else begin
      clamp_sat = {1'b0, acc};
    end
  endfunction

endpackage

// File: rtl/audio_mix_dac_sd_dac_1bit.sv
// One-bit audio modulator: leaky-integrator comparator and first-order delta-sigma,
// both always running so the mode select can switch between them without a glitch.
module sd_dac_1bit
  import audio_mix_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int FILT_SHIFT = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] u,
  input  logic                dac_mode,
  output logic                dac_bit
);

  localparam int VW = IN_WIDTH + 16;

  logic [VW-1:0]     v_r;
  logic [VW-1:0]     v_nxt_s;
  logic [IN_WIDTH:0] a_r;
  logic [IN_WIDTH:0] a_nxt_s;
  logic              leaky_bit_s;

  // Next state of both modulators.
  always_comb begin
    leaky_bit_s = (v_r[VW-1 -: IN_WIDTH] < u);
    v_nxt_s     = v_r - (v_r >> FILT_SHIFT)
                + (leaky_bit_s ? (VW'(1) << (VW - FILT_SHIFT)) : VW'(0));
    a_nxt_s     = {1'b0, a_r[IN_WIDTH-1:0]} + {1'b0, u};
  end

  // Modulator state and the registered output bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_r     <= '0;
      a_r     <= '0;
      dac_bit <= 1'b0;
    end else begin
      v_r     <= v_nxt_s;
      a_r     <= a_nxt_s;
      dac_bit <= (dac_mode == DAC_DSM) ? a_nxt_s[IN_WIDTH] : leaky_bit_s;
    end
  end

endmodule

// File: rtl/audio_mix_dac.sv
// N-source stereo mixer (shift gain, mute, L/R routing, saturating sum) feeding
// one 1-bit modulator per side.
module audio_mix_dac
  import audio_mix_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int IN_WIDTH   = 16,
  parameter int FILT_SHIFT = 7
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sample_en,
  input  logic [CHANNELS*IN_WIDTH-1:0] ch_data,
  input  logic [CHANNELS*3-1:0]        ch_gain,
  input  logic [CHANNELS-1:0]          ch_mute,
  input  logic [CHANNELS-1:0]          ch_route_l,
  input  logic [CHANNELS-1:0]          ch_route_r,
  input  logic                         dac_mode,
  output logic [IN_WIDTH-1:0]          mix_l,
  output logic [IN_WIDTH-1:0]          mix_r,
  output logic                         clip_l,
  output logic                         clip_r,
  output logic                         busy,
  output logic                         overrun,
  output logic                         aud_l,
  output logic                         aud_r
);

  localparam int ACC_W = acc_width(CHANNELS, IN_WIDTH);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  mix_state_t                   state_r;
  mix_state_t                   state_nxt_s;
  logic [IDX_W-1:0]             idx_r;
  logic signed [ACC_W-1:0]      acc_l_r;
  logic signed [ACC_W-1:0]      acc_r_r;
  logic signed [ACC_W-1:0]      term_s;
  logic [IN_WIDTH-1:0]          sample_s;
  logic [2:0]                   shift_s;
  logic [CHANNELS*IN_WIDTH-1:0] data_r;
  logic [CHANNELS*3-1:0]        gain_r;
  logic [CHANNELS-1:0]          mute_r;
  logic [CHANNELS-1:0]          route_l_r;
  logic [CHANNELS-1:0]          route_r_r;
  logic [64:0]                  sat_l_s;
  logic [64:0]                  sat_r_s;
  logic                         unused_sat_s;
  logic [IN_WIDTH-1:0]          u_l_s;
  logic [IN_WIDTH-1:0]          u_r_s;

  assign busy    = (state_r != IDLE);
  assign overrun = sample_en && (state_r != IDLE);

  assign sat_l_s      = clamp_sat(64'(acc_l_r), IN_WIDTH);
  assign sat_r_s      = clamp_sat(64'(acc_r_r), IN_WIDTH);
  assign unused_sat_s = ^{sat_l_s[63:IN_WIDTH], sat_r_s[63:IN_WIDTH]};

  // Offset-binary view of the signed mix for the modulators.
  assign u_l_s = {~mix_l[IN_WIDTH-1], mix_l[IN_WIDTH-2:0]};
  assign u_r_s = {~mix_r[IN_WIDTH-1], mix_r[IN_WIDTH-2:0]};

  // Control state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_en) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = CLAMP;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      CLAMP:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Gained, sign-extended contribution of the current channel.
  always_comb begin
    sample_s = data_r[int'(idx_r)*IN_WIDTH +: IN_WIDTH];
    shift_s  = gain_r[int'(idx_r)*3 +: 3];
    if (mute_r[idx_r]) begin
      term_s = '0;
    end else begin
      term_s = {{(ACC_W-IN_WIDTH){sample_s[IN_WIDTH-1]}}, sample_s} <<< shift_s;
    end
  end

  // Snapshot, accumulation and clamped result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_r     <= '0;
      acc_l_r   <= '0;
      acc_r_r   <= '0;
      data_r    <= '0;
      gain_r    <= '0;
      mute_r    <= '0;
      route_l_r <= '0;
      route_r_r <= '0;
      mix_l     <= '0;
      mix_r     <= '0;
      clip_l    <= 1'b0;
      clip_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sample_en) begin
            data_r    <= ch_data;
            gain_r    <= ch_gain;
            mute_r    <= ch_mute;
            route_l_r <= ch_route_l;
            route_r_r <= ch_route_r;
            acc_l_r   <= '0;
            acc_r_r   <= '0;
            idx_r     <= '0;
          end
        end
        ACCUM: begin
          if (route_l_r[idx_r]) begin
            acc_l_r <= acc_l_r + term_s;
          end
          if (route_r_r[idx_r]) begin
            acc_r_r <= acc_r_r + term_s;
          end
          if (idx_r != LAST_IDX) begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        CLAMP: begin
          mix_l  <= sat_l_s[IN_WIDTH-1:0];
          mix_r  <= sat_r_s[IN_WIDTH-1:0];
          clip_l <= sat_l_s[64];
          clip_r <= sat_r_s[64];
        end
        default: begin
        end
      endcase
    end
  end

  sd_dac_1bit #(
    .IN_WIDTH  (IN_WIDTH),
    .FILT_SHIFT(FILT_SHIFT)
  ) u_dac_l (
    .clock   (clock),
    .reset   (reset),
    .u       (u_l_s),
    .dac_mode(dac_mode),
    .dac_bit (aud_l)
  );

  sd_dac_1bit #(
    .IN_WIDTH  (IN_WIDTH),
    .FILT_SHIFT(FILT_SHIFT)
  ) u_dac_r (
    .clock   (clock),
    .reset   (reset),
    .u       (u_r_s),
    .dac_mode(dac_mode),
    .dac_bit (aud_r)
  );

endmodule
